// File: rtl/arb8_rr_controller_if.sv
// arb8_rr_controller_if: request/grant bundle between 8 requesters and the arbiter
//   req       : requester -> arbiter, bit i = requester i
//   gnt       : arbiter -> requester, one-hot grant (zero when idle)
//   gnt_idx   : arbiter -> requester, binary index of the granted requester
//   gnt_valid : arbiter -> requester, OR of gnt
//   preempt   : arbiter -> requester, one-cycle pulse when a grant moves on timeout
interface arb8_rr_controller_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;
    modport master (output req, input gnt, gnt_idx, gnt_valid, preempt);
    modport slave (input req, output gnt, gnt_idx, gnt_valid, preempt);
endinterface

// File: rtl/arb8_rr_controller.sv
// arb8_rr_controller: 8-way arbiter with registered one-hot grant and hold timeout
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of arb8_rr_controller_if (req in; gnt/gnt_idx/gnt_valid/preempt out)
// Selection is fixed priority (index 7 highest) unless ARB_RR_EN is defined,
// which enables round-robin search starting after the last winner.
module arb8_rr_controller #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    arb8_rr_controller_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [2:0]         idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               preempt_q, preempt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_req, others, at_limit, timeout, arb;
    logic [7:0]         masked;
    logic [2:0]         win;

`ifdef ARB_RR_EN
    logic [2:0] last_q, last_d;

    // First set bit searching upward from last+1, wrapping modulo 8.
    function automatic logic [2:0] pick_rr(input logic [7:0] r, input logic [2:0] last);
        logic       found;
        logic [2:0] j;
        pick_rr = '0;
        found   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            j = 3'(32'(last) + i);
            if (!found && r[j]) begin
                pick_rr = j;
                found   = 1'b1;
            end
        end
    endfunction
`else
    function automatic logic [2:0] pick_fixed(input logic [7:0] r);
        pick_fixed = '0;
        for (int i = 0; i < 8; i++)
            if (r[i]) pick_fixed = 3'(i);
    endfunction
`endif

    always_comb begin
        owner_req = |(bus.req & gnt_q);
        others    = |(bus.req & ~gnt_q);
        at_limit  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD - 1));
        // Release wins over timeout: a dropped owner simply hands off without preempt.
        timeout   = (state_q == GRANT) && owner_req && at_limit && others;
        masked    = timeout ? (bus.req & ~gnt_q) : bus.req;
`ifdef ARB_RR_EN
        win       = pick_rr(masked, last_q);
`else
        win       = pick_fixed(masked);
`endif
        arb       = (state_q == IDLE) || !owner_req || timeout;
        state_d   = state_q;
        gnt_d     = gnt_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
`ifdef ARB_RR_EN
        last_d    = last_q;
`endif
        if (arb) begin
            cnt_d = '0;
            if (|masked) begin
                state_d   = GRANT;
                gnt_d     = 8'b1 << win;
                idx_d     = win;
                preempt_d = timeout;
`ifdef ARB_RR_EN
                last_d    = win;
`endif
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                idx_d   = '0;
            end
        end else if (at_limit) begin
            // Sole requester at the limit keeps the grant; restart the hold window.
            cnt_d = '0;
        end else begin
            cnt_d = (cnt_q == CNT_W'(MAX_HOLD)) ? cnt_q : cnt_q + CNT_W'(1);
        end
        valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            cnt_q     <= '0;
`ifdef ARB_RR_EN
            last_q    <= 3'd7;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            cnt_q     <= cnt_d;
`ifdef ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.preempt   = preempt_q;
endmodule

// File: tb/tb_arb8_rr_controller.sv
// tb_arb8_rr_controller: directed checks of arb8_rr_controller with MAX_HOLD=4
module tb_arb8_rr_controller;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    arb8_rr_controller_if bus ();

    arb8_rr_controller #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eg, input logic [2:0] ei, input logic ep);
        checks++;
        assert (bus.gnt === eg) else begin
            errors++;
            $error("FAIL %s gnt got %h expected %h", tag, bus.gnt, eg);
        end
        assert (bus.gnt_idx === ei) else begin
            errors++;
            $error("FAIL %s gnt_idx got %0d expected %0d", tag, bus.gnt_idx, ei);
        end
        assert (bus.gnt_valid === (eg != 8'h00)) else begin
            errors++;
            $error("FAIL %s gnt_valid got %b expected %b", tag, bus.gnt_valid, eg != 8'h00);
        end
        assert (bus.preempt === ep) else begin
            errors++;
            $error("FAIL %s preempt got %b expected %b", tag, bus.preempt, ep);
        end
    endtask

    initial begin
        logic [7:0] rr_exp [8];
        checks = 0;
        errors = 0;
        rst_n   = 1'b0;
        bus.req = 8'h00;
        #12;
        chk("reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle", 8'h00, 3'd0, 1'b0);
        end

        // Two requesters, then zero-bubble hand-off on release.
        bus.req = 8'h22;
        tick();
`ifdef ARB_RR_EN
        chk("rr_first", 8'h02, 3'd1, 1'b0);
        bus.req = 8'h20;
        tick();
        chk("rr_handoff", 8'h20, 3'd5, 1'b0);
`else
        chk("fixed_first", 8'h20, 3'd5, 1'b0);
        bus.req = 8'h02;
        tick();
        chk("fixed_handoff", 8'h02, 3'd1, 1'b0);
`endif
        bus.req = 8'h00;
        tick();
        chk("release_idle", 8'h00, 3'd0, 1'b0);

        // Timeout hand-off in both directions.
        bus.req = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold7", 8'h80, 3'd7, 1'b0);
        end
        tick();
        chk("preempt_to0", 8'h01, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold0", 8'h01, 3'd0, 1'b0);
        end
        tick();
        chk("preempt_to7", 8'h80, 3'd7, 1'b1);
        tick();
        chk("after_preempt", 8'h80, 3'd7, 1'b0);
        bus.req = 8'h00;
        tick();
        chk("idle2", 8'h00, 3'd0, 1'b0);

        // Sole requester never gets preempted.
        bus.req = 8'h08;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("sole", 8'h08, 3'd3, 1'b0);
        end
        bus.req = 8'h00;
        tick();
        chk("idle3", 8'h00, 3'd0, 1'b0);

`ifdef ARB_RR_EN
        // Round-robin order 0..7,0 from a fresh pointer.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        rr_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        bus.req = 8'hFF;
        tick();
        chk("rr_start", 8'h01, 3'd0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.req = 8'hFF & ~bus.gnt;
            tick();
            chk("rr_order", rr_exp[k], 3'((k + 1) % 8), 1'b0);
            bus.req = 8'hFF;
        end
        bus.req = 8'h00;
        tick();
        chk("rr_idle", 8'h00, 3'd0, 1'b0);
`else
        rr_exp = '{default: 8'h00};
`endif

        // Asynchronous reset mid-grant.
        bus.req = 8'h10;
        tick();
        chk("pre_reset", 8'h10, 3'd4, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 8'h00, 3'd0, 1'b0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post_reset", 8'h10, 3'd4, 1'b0);

        // Pointer back to 7 after reset: {5,4} picks 4 in RR, 5 in fixed.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        bus.req = 8'h30;
        tick();
`ifdef ARB_RR_EN
        chk("ptr_reset", 8'h10, 3'd4, 1'b0);
`else
        chk("ptr_reset", 8'h20, 3'd5, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/arb8_rr_controller.md
Name: arb8_rr_controller

Overview:
- Arbiter that shares one resource among 8 requesters, using the same 8-bit request vector / 3-bit index / valid convention as the 8x3 priority encoder.
- Produces a registered one-hot grant plus the encoded winner index.
- The grant is held until the owner drops its request or a hold timeout forces a hand-off.
- Selection is fixed-priority (index 7 highest) by default, or round-robin when the optional feature is compiled in.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant while others wait; 0 disables the timeout.
- CNT_W, 5, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  8  request vector; bit i = requester i
- gnt  out  8  registered one-hot grant; all zero when idle
- gnt_idx  out  3  binary index of the granted requester; 0 when idle
- gnt_valid  out  1  high while any grant is active (equals OR of gnt)
- preempt  out  1  one-cycle pulse in the cycle a grant moves because of timeout

Behaviour:
- Reset: clock and reset are single, asynchronous, active-low on rst_n (already decided).
  - All outputs reset to 0: gnt, gnt_idx, gnt_valid, preempt.
  - State resets to IDLE; hold counter resets to 0; RR pointer `last` resets to 7.
  - Reset asserted mid-grant drops gnt asynchronously, with no release handshake.
- States:
  - IDLE: no grant. If req != 0, arbitrate and go to GRANT; the registered grant appears on the next rising edge, giving 1 cycle req->gnt latency.
  - GRANT: the owner holds the resource. The counter increments each cycle in GRANT and saturates at MAX_HOLD.
- Release: req[owner] == 0 in GRANT, sampled at the clock edge.
  - If other requests are pending, the new winner is registered on that same edge (zero-bubble hand-off); the counter clears.
  - Otherwise go to IDLE; gnt = 0 on that edge.
- Timeout: MAX_HOLD != 0, count == MAX_HOLD-1, and req has a bit set other than the owner.
  - The owner is masked out of this arbitration round and the new winner is registered.
  - preempt = 1 for exactly that cycle; the counter clears.
  - If the owner is the only requester, the grant stays, the counter clears, and there is no preempt.
- Arbitration function is combinational over the masked request vector:
  - fixed priority: highest set index wins.
  - round-robin: first set index searching upward from (last+1) mod 8 with wrap-around.
- `last` updates to the winner index on every new grant.
- Requests arriving mid-grant are not serviced until release or timeout; no queuing.
- req bits for non-owners may toggle freely; only their value at arbitration edges matters.
- gnt is always one-hot or zero. gnt_idx is always the encoding of gnt. gnt_valid is always the OR of gnt.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin search from (last+1) mod 8, with `last` register present.
- Not defined: fixed priority, index 7 highest; no `last` register.
  - Timeout masking still applies, so a waiting lower-priority requester is granted after MAX_HOLD cycles.

Test Plan:
- Reset, then req=8'h00 for 5 cycles -> gnt=0, gnt_idx=0, gnt_valid=0, preempt=0 throughout.
- Fixed priority: req=8'h22 at edge N -> gnt=8'h20, gnt_idx=5 after edge N. Drop req[5] -> gnt=8'h02, gnt_idx=1 on the next edge, with no idle cycle.
- Timeout, MAX_HOLD=4: req=8'h81 held constant -> gnt=8'h80 for exactly 4 cycles, then gnt=8'h01 with preempt=1 for 1 cycle. Fixed mode: back to 8'h80 after 4 more cycles.
- ARB_RR_EN defined: req=8'hFF held, each owner dropping its req for 1 cycle after being granted -> grant order 0,1,2,...,7,0.
- Sole requester, MAX_HOLD=4: req=8'h08 for 12 cycles -> gnt=8'h08 continuously, preempt never asserted.
- Reset asserted mid-grant (gnt=8'h10) -> gnt=0 immediately, without waiting for a clock edge. After release, with req=8'h10, gnt=8'h10 one cycle later; RR pointer back to 7.
